gain_mult_scheduler: RTL

GAIN_MULT_SCHEDULER -- requirements
Module: gain_mult_scheduler

---
 rtl/audio_pkg.sv | 18 +
 rtl/seqmultNM.sv | 45 ++++
 rtl/gain_mult_scheduler.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared constants and FSM encoding for the audio gain/multiplier scheduler.
package audio_pkg;

   localparam int AUDIO_DW    = 18;
   localparam int AUDIO_KW    = 4;
   localparam int AUDIO_SHIFT = 3;

   // One sample walks the states in declaration order and then returns to IDLE.
   typedef enum logic [2:0] {
      IDLE,
      START_S,
      WAIT_S,
      START_D,
      WAIT_D,
      DONE
   } sched_state_t;

endpackage

// File: rtl/seqmultNM.sv
// Shared sequential signed multiplier that lives outside the scheduler.
// A start taken while idle holds ready low for exactly N clocks; R is valid
// from the first clock on which ready returns high.
module seqmultNM #(
   parameter int M = 18,
   parameter int N = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic signed [M-1:0]   A,
   input  logic signed [N-1:0]   B,
   output logic                  ready,
   output logic signed [M+N-1:0] R
);

   localparam int CW = $clog2(N + 1);

   logic [CW-1:0]          count;
   logic signed [M+N-1:0]  prod;
   logic signed [M+N-1:0]  a_ext;
   logic signed [M+N-1:0]  b_ext;

   assign a_ext = {{N{A[M-1]}}, A};
   assign b_ext = {{M{B[N-1]}}, B};
   assign ready = (count == '0);

   // Take a product on start, count down the busy window, publish R at its end.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         prod  <= '0;
         R     <= '0;
      end else if (start && ready) begin
         prod  <= a_ext * b_ext;
         count <= CW'(N);
      end else if (count != '0) begin
         count <= count - CW'(1);
         if (count == CW'(1)) begin
            R <= prod;
         end
      end
   end

endmodule

// File: rtl/gain_mult_scheduler.sv
// Scales (L+R)/2 by Ks and (L-R)/2 by Kd using one shared external
// multiplier, sum channel first, then difference channel, once per sample.
//
// Handshake with the multiplier: mult_start is a one-cycle request issued in a
// START state with mult_A/mult_B already valid; the operands stay stable through
// the following WAIT state, which first sees mult_ready low (busy) and then
// completes on the first cycle mult_ready is high again, sampling mult_R there.
module gain_mult_scheduler
   import audio_pkg::*;
#(
   parameter int DW    = AUDIO_DW,
   parameter int KW    = AUDIO_KW,
   parameter int SHIFT = AUDIO_SHIFT
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   clken_48,
   input  logic signed [DW-1:0]   LEFT,
   input  logic signed [DW-1:0]   RIGHT,
   input  logic [KW-1:0]          Ks,
   input  logic [KW-1:0]          Kd,
   output logic                   mult_start,
   output logic signed [DW-1:0]   mult_A,
   output logic signed [KW:0]     mult_B,
   input  logic                   mult_ready,
   input  logic signed [DW+KW:0]  mult_R,
   output logic signed [DW-1:0]   LI_in_LpR,
   output logic signed [DW-1:0]   LI_in_LmR,
   output logic                   out_valid,
   output logic                   overrun
);

   sched_state_t state, next_state;

   logic signed [DW-1:0] l_q, r_q;
   logic [KW-1:0]        ks_q, kd_q;
   logic                 busy_seen;
   logic signed [DW-1:0] hold_s, hold_d;
   logic signed [DW:0]   sum_full, diff_full;
   logic signed [DW-1:0] sum_half, diff_half;
   logic signed [DW-1:0] prod_scaled;
   logic                 wait_exit;

   // Operands are formed one bit wider so the halving never overflows.
   assign sum_full    = {l_q[DW-1], l_q} + {r_q[DW-1], r_q};
   assign diff_full   = {l_q[DW-1], l_q} - {r_q[DW-1], r_q};
   assign sum_half    = DW'(sum_full >>> 1);
   assign diff_half   = DW'(diff_full >>> 1);
   assign prod_scaled = DW'(mult_R >>> SHIFT);
   assign wait_exit   = busy_seen & mult_ready;

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state, multiplier request/operands and the overrun pulse.
   always_comb begin
      next_state = state;
      mult_start = 1'b0;
      mult_A     = '0;
      mult_B     = '0;
      overrun    = 1'b0;
      case (state)
         IDLE: begin
            if (clken_48) next_state = START_S;
         end
         START_S: begin
            mult_start = 1'b1;
            mult_A     = sum_half;
            mult_B     = {1'b0, ks_q};
            next_state = WAIT_S;
         end
         WAIT_S: begin
            mult_A = sum_half;
            mult_B = {1'b0, ks_q};
            if (wait_exit) next_state = START_D;
         end
         START_D: begin
            mult_start = 1'b1;
            mult_A     = diff_half;
            mult_B     = {1'b0, kd_q};
            next_state = WAIT_D;
         end
         WAIT_D: begin
            mult_A = diff_half;
            mult_B = {1'b0, kd_q};
            if (wait_exit) next_state = DONE;
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
      // A strobe outside IDLE is dropped; flag it in the same cycle.
      if (clken_48 && (state != IDLE)) overrun = 1'b1;
      if (reset) begin
         next_state = IDLE;
         mult_start = 1'b0;
         mult_A     = '0;
         mult_B     = '0;
         overrun    = 1'b0;
      end
   end

   // Sample capture, product holding registers and the output update.
   always_ff @(posedge clock) begin
      if (reset) begin
         l_q       <= '0;
         r_q       <= '0;
         ks_q      <= '0;
         kd_q      <= '0;
         busy_seen <= 1'b0;
         hold_s    <= '0;
         hold_d    <= '0;
         LI_in_LpR <= '0;
         LI_in_LmR <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (clken_48) begin
                  l_q  <= LEFT;
                  r_q  <= RIGHT;
                  ks_q <= Ks;
                  kd_q <= Kd;
               end
            end
            WAIT_S, WAIT_D: begin
               if (!mult_ready) begin
                  busy_seen <= 1'b1;
               end else if (busy_seen) begin
                  busy_seen <= 1'b0;
                  if (state == WAIT_S) hold_s <= prod_scaled;
                  else                 hold_d <= prod_scaled;
               end
            end
            DONE: begin
               LI_in_LpR <= hold_s;
               LI_in_LmR <= hold_d;
               out_valid <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
